// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared definitions for the note_feeder chart scroller:
//   - chart ROM codes (NOTE_NONE / NOTE_RED / NOTE_BLUE / NOTE_END)
//   - judge grade to point conversion and point constants
//   - scroller FSM state encoding
//   - score / combo widths and saturation limits
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int SCORE_W = 14;
    localparam int COMBO_W = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [COMBO_W-1:0] COMBO_MAX = {COMBO_W{1'b1}};

    typedef enum logic [1:0] {
        NOTE_NONE = 2'b00,
        NOTE_RED  = 2'b01,
        NOTE_BLUE = 2'b10,
        NOTE_END  = 2'b11
    } note_code_e;

    localparam logic [2:0] PTS_PERFECT = 3'd3;
    localparam logic [2:0] PTS_GOOD    = 3'd2;
    localparam logic [2:0] PTS_BAD     = 3'd1;
    localparam logic [2:0] PTS_NONE    = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // Judge grade (3 perfect .. 0 none) to base points, before any bonus.
    function automatic logic [2:0] grade_points(input logic [1:0] grade);
        logic [2:0] pts;
        case (grade)
            2'd3:    pts = PTS_PERFECT;
            2'd2:    pts = PTS_GOOD;
            2'd1:    pts = PTS_BAD;
            default: pts = PTS_NONE;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/note_feeder_step_tick.sv
// -----------------------------------------------------------------------------
// step_tick
// Free-running TICK_DIV divider producing a one-cycle scroll step pulse.
// Ports:
//   clk  in  : system clock
//   rst  in  : synchronous active-low reset
//   clr  in  : synchronous clear, restarts the period from zero
//   en   in  : count enable; while low the counter is held at zero
//   step out : registered one-cycle pulse, once every TICK_DIV cycles
// -----------------------------------------------------------------------------
module step_tick #(
    parameter int TICK_DIV = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             step_r;

    // Period counter and step pulse register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r  <= '0;
            step_r <= 1'b0;
        end else if (clr || !en) begin
            cnt_r  <= '0;
            step_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= '0;
            step_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            step_r <= 1'b0;
        end
    end

    assign step = step_r;

endmodule

// File: rtl/note_feeder.sv
// -----------------------------------------------------------------------------
// note_feeder
// Reads a red/blue note chart from a synchronous ROM and scrolls the notes
// along one lane toward the hit line. Presents the head note inside the judge
// window, removes it on delete_note, accumulates score / combo and exports
// lane occupancy for the renderer.
// Ports:
//   clk, rst (sync active-low)      : clock / reset
//   start                           : begin / restart play (IDLE or DONE only)
//   chart_addr / chart_data         : chart ROM address / data (1-cycle latency)
//   delete_note, score              : judge consumed head note with grade
//   offset, node_R, node_B          : head position in window and its colour
//   lane_red, lane_blue             : per-cell occupancy
//   miss                            : one-cycle pulse, note left cell 0 unhit
//   total_score, combo              : saturating running totals
//   playing, done                   : status
// Build option: NOTE_FEEDER_COMBO_BONUS_EN doubles points while combo >= 10.
// -----------------------------------------------------------------------------
module note_feeder
    import note_pkg::*;
#(
    parameter int LANE_LEN = 8,
    parameter int WIN      = 5,
    parameter int TICK_DIV = 5_000_000,
    parameter int CHART_AW = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic [CHART_AW-1:0] chart_addr,
    input  logic [1:0]          chart_data,
    input  logic                delete_note,
    input  logic [1:0]          score,
    output logic [2:0]          offset,
    output logic                node_R,
    output logic                node_B,
    output logic [LANE_LEN-1:0] lane_red,
    output logic [LANE_LEN-1:0] lane_blue,
    output logic                miss,
    output logic [SCORE_W-1:0]  total_score,
    output logic [COMBO_W-1:0]  combo,
    output logic                playing,
    output logic                done
);

    localparam logic [LANE_LEN-1:0] WIN_MASK  = LANE_LEN'((1 << WIN) - 1);
    localparam logic [CHART_AW-1:0] ADDR_LAST = {CHART_AW{1'b1}};

    state_e              state_r, state_s;
    logic [LANE_LEN-1:0] lane_red_r, lane_blue_r, red_s, blue_s;
    logic [CHART_AW-1:0] addr_r, addr_s;
    logic [SCORE_W-1:0]  total_r, total_s;
    logic [COMBO_W-1:0]  combo_r, combo_s;
    logic                miss_r, miss_s;
    logic                playing_r, done_r;
    logic                clr_s, active_s, step_s, del_ok_s;
    logic [LANE_LEN-1:0] occ_s, head_oh_s;
    logic                in_win_s;
    logic [2:0]          offset_s, base_pts_s, pts_s;
    logic [SCORE_W:0]    sum_s;

    step_tick #(.TICK_DIV(TICK_DIV)) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .en   (active_s),
        .step (step_s)
    );

    // Head note: isolate the lowest occupied cell as a one-hot mask.
    assign occ_s     = lane_red_r | lane_blue_r;
    assign head_oh_s = occ_s & (~occ_s + LANE_LEN'(1));
    assign in_win_s  = |(head_oh_s & WIN_MASK);
    assign active_s  = (state_r == ST_PLAY) || (state_r == ST_DRAIN);
    assign del_ok_s  = delete_note && active_s && in_win_s;

    // Window offset: cell h maps to WIN-h, cells outside the window give 0.
    always_comb begin
        offset_s = 3'd0;
        for (int i = 0; i < WIN; i++) begin
            offset_s = offset_s | (head_oh_s[i] ? 3'(WIN - i) : 3'd0);
        end
    end

    assign base_pts_s = grade_points(score);
`ifdef NOTE_FEEDER_COMBO_BONUS_EN
    assign pts_s = (combo_r >= COMBO_W'(10)) ? {base_pts_s[1:0], 1'b0} : base_pts_s;
`else
    assign pts_s = base_pts_s;
`endif
    assign sum_s = {1'b0, total_r} + {{(SCORE_W - 2){1'b0}}, pts_s};

    // Next-state logic: lane scrolling, chart loading, scoring and miss.
    always_comb begin
        state_s = state_r;
        red_s   = lane_red_r;
        blue_s  = lane_blue_r;
        addr_s  = addr_r;
        total_s = total_r;
        combo_s = combo_r;
        miss_s  = 1'b0;
        clr_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s = ST_PLAY;
                    clr_s   = 1'b1;
                    red_s   = '0;
                    blue_s  = '0;
                    addr_s  = '0;
                    total_s = '0;
                    combo_s = '0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PLAY, ST_DRAIN: begin
                if ((state_r == ST_DRAIN) && (occ_s == '0)) begin
                    state_s = ST_DONE;
                end else begin
                    // Delete acts on the pre-shift head, so a note deleted
                    // from cell 0 on a step edge is not reported as a miss.
                    if (del_ok_s) begin
                        red_s   = red_s & ~head_oh_s;
                        blue_s  = blue_s & ~head_oh_s;
                        total_s = sum_s[SCORE_W] ? SCORE_MAX : sum_s[SCORE_W-1:0];
                        if (score != 2'd0) begin
                            combo_s = (combo_r == COMBO_MAX) ? COMBO_MAX : combo_r + COMBO_W'(1);
                        end else begin
                            combo_s = '0;
                        end
                    end else begin
                        combo_s = combo_r;
                    end
                    if (step_s) begin
                        miss_s = red_s[0] | blue_s[0];
                        if (miss_s) begin
                            combo_s = '0;
                        end else begin
                            combo_s = combo_s;
                        end
                        red_s  = red_s >> 1;
                        blue_s = blue_s >> 1;
                        if (state_r == ST_PLAY) begin
                            if (chart_data == NOTE_END) begin
                                state_s = ST_DRAIN;
                            end else begin
                                red_s[LANE_LEN-1]  = (chart_data == NOTE_RED);
                                blue_s[LANE_LEN-1] = (chart_data == NOTE_BLUE);
                                // Last ROM entry: loaded, then drain without wrapping.
                                if (addr_r == ADDR_LAST) begin
                                    state_s = ST_DRAIN;
                                end else begin
                                    addr_s = addr_r + CHART_AW'(1);
                                end
                            end
                        end else begin
                            state_s = ST_DRAIN;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, lane, score and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            lane_red_r  <= '0;
            lane_blue_r <= '0;
            addr_r      <= '0;
            total_r     <= '0;
            combo_r     <= '0;
            miss_r      <= 1'b0;
            playing_r   <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            lane_red_r  <= red_s;
            lane_blue_r <= blue_s;
            addr_r      <= addr_s;
            total_r     <= total_s;
            combo_r     <= combo_s;
            miss_r      <= miss_s;
            playing_r   <= (state_s == ST_PLAY) || (state_s == ST_DRAIN);
            done_r      <= (state_s == ST_DONE);
        end
    end

    assign chart_addr  = addr_r;
    assign offset      = offset_s;
    assign node_R      = |(head_oh_s & WIN_MASK & lane_red_r);
    assign node_B      = |(head_oh_s & WIN_MASK & lane_blue_r);
    assign lane_red    = lane_red_r;
    assign lane_blue   = lane_blue_r;
    assign miss        = miss_r;
    assign total_score = total_r;
    assign combo       = combo_r;
    assign playing     = playing_r;
    assign done        = done_r;

endmodule

// File: tb/tb_note_feeder.sv
// -----------------------------------------------------------------------------
// tb_note_feeder
// Directed self-checking bench for note_feeder with TICK_DIV = 4. A small
// behavioural chart ROM (one-cycle read latency) is rewritten between runs.
// -----------------------------------------------------------------------------
module tb_note_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  chart_addr;
    logic [1:0]  chart_data;
    logic        delete_note = 1'b0;
    logic [1:0]  score = 2'd0;
    logic [2:0]  offset;
    logic        node_R, node_B;
    logic [7:0]  lane_red, lane_blue;
    logic        miss;
    logic [13:0] total_score;
    logic [7:0]  combo;
    logic        playing, done;

    logic [1:0]  rom [0:63];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    int          n;

    note_feeder #(
        .LANE_LEN (8),
        .WIN      (5),
        .TICK_DIV (4),
        .CHART_AW (6)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .chart_addr  (chart_addr),
        .chart_data  (chart_data),
        .delete_note (delete_note),
        .score       (score),
        .offset      (offset),
        .node_R      (node_R),
        .node_B      (node_B),
        .lane_red    (lane_red),
        .lane_blue   (lane_blue),
        .miss        (miss),
        .total_score (total_score),
        .combo       (combo),
        .playing     (playing),
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) chart_data <= rom[chart_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_lane_red"},  32'(lane_red),    32'd0);
        chk({tag, "_lane_blue"}, 32'(lane_blue),   32'd0);
        chk({tag, "_addr"},      32'(chart_addr),  32'd0);
        chk({tag, "_total"},     32'(total_score), 32'd0);
        chk({tag, "_combo"},     32'(combo),       32'd0);
        chk({tag, "_miss"},      32'(miss),        32'd0);
        chk({tag, "_offset"},    32'(offset),      32'd0);
        chk({tag, "_playing"},   32'(playing),     32'd0);
        chk({tag, "_done"},      32'(done),        32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 2'b11;

        // Reset held for two cycles.
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b1;

        // Run 1: chart {red, none, none, end}.
        rom[0] = 2'b01; rom[1] = 2'b00; rom[2] = 2'b00; rom[3] = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r1_playing", 32'(playing), 32'd1);
        n = 0;
        while (lane_red !== 8'b0000_0100 && n < 200) begin tick(); n++; end
        chk("r1_wait_cell2", 32'(lane_red), 32'h04);
        chk("r1_offset", 32'(offset), 32'd3);
        chk("r1_node_R", 32'(node_R), 32'd1);
        chk("r1_node_B", 32'(node_B), 32'd0);
        delete_note = 1'b1; score = 2'd3;
        tick();
        delete_note = 1'b0; score = 2'd0;
        chk("r1_del_offset", 32'(offset), 32'd0);
        chk("r1_del_total", 32'(total_score), 32'd3);
        chk("r1_del_combo", 32'(combo), 32'd1);
        chk("r1_del_lane", 32'(lane_red), 32'd0);
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        chk("r1_done", 32'(done), 32'd1);
        chk("r1_done_playing", 32'(playing), 32'd0);

        // Run 2: chart {red, blue, red, end}, restarted from DONE.
        rom[0] = 2'b01; rom[1] = 2'b10; rom[2] = 2'b01; rom[3] = 2'b11;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("r2_restart_total", 32'(total_score), 32'd0);
        chk("r2_restart_combo", 32'(combo), 32'd0);
        chk("r2_restart_done", 32'(done), 32'd0);
        n = 0;
        while (lane_red !== 8'b0010_1000 && n < 200) begin tick(); n++; end
        chk("r2_wait_lane", 32'(lane_red), 32'h28);
        chk("r2_lane_blue", 32'(lane_blue), 32'h10);
        chk("r2_offset_c3", 32'(offset), 32'd2);
        chk("r2_node_R_c3", 32'(node_R), 32'd1);
        delete_note = 1'b1; score = 2'd3;
        tick();
        delete_note = 1'b0; score = 2'd0;
        chk("r2_hit_total", 32'(total_score), 32'd3);
        chk("r2_hit_combo", 32'(combo), 32'd1);
        chk("r2_blue_offset", 32'(offset), 32'd1);
        chk("r2_blue_node_B", 32'(node_B), 32'd1);
        chk("r2_blue_node_R", 32'(node_R), 32'd0);

        // Blue left unhit: the step after it reaches cell 0 raises a miss.
        n = 0;
        while (lane_blue[0] !== 1'b1 && n < 200) begin tick(); n++; end
        chk("r2_wait_blue_c0", 32'(lane_blue), 32'h01);
        chk("r2_blue_c0_offset", 32'(offset), 32'd5);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("r2_pre_miss", 32'(miss), 32'd0);
        end
        tick();
        chk("r2_miss", 32'(miss), 32'd1);
        chk("r2_miss_combo", 32'(combo), 32'd0);
        chk("r2_miss_total", 32'(total_score), 32'd3);
        chk("r2_miss_lane_blue", 32'(lane_blue), 32'd0);
        chk("r2_red_c0", 32'(lane_red), 32'h01);
        tick();
        chk("r2_miss_one_cycle", 32'(miss), 32'd0);

        // Delete coincident with the step while the head sits in cell 0.
        tick();
        tick();
        delete_note = 1'b1; score = 2'd2;
        tick();
        delete_note = 1'b0; score = 2'd0;
        chk("r2_coinc_miss", 32'(miss), 32'd0);
        chk("r2_coinc_lane", 32'(lane_red), 32'd0);
        chk("r2_coinc_total", 32'(total_score), 32'd5);
        chk("r2_coinc_combo", 32'(combo), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin tick(); n++; end
        chk("r2_done", 32'(done), 32'd1);

        // Run 3: reset in the middle of play.
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while ((lane_red == 8'd0 || chart_addr == 6'd0) && n < 200) begin tick(); n++; end
        chk("r3_active", 32'(playing), 32'd1);
        rst = 1'b0;
        tick();
        chk_all_zero("midreset");
        rst = 1'b1;
        tick();
        chk("r3_stays_idle", 32'(playing), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
